// File: rtl/program_sequencer_stack_if.sv
// Control and status bundle between an instruction decoder and the program sequencer.
// The decoder side drives the jump/call/return requests; the sequencer reports fetch address and stack state.
interface program_sequencer_stack_if #(
  parameter int PC_WIDTH    = 8,
  parameter int JA_WIDTH    = 4,
  parameter int STACK_DEPTH = 4,
  parameter int SP_WIDTH    = $clog2(STACK_DEPTH + 1)
);
  logic                hold;
  logic                jmp;
  logic                jmp_nz;
  logic                dont_jmp;
  logic                call;
  logic                ret;
  logic [JA_WIDTH-1:0] jmp_addr;
  logic [PC_WIDTH-1:0] pm_addr;
  logic [PC_WIDTH-1:0] pc;
  logic [SP_WIDTH-1:0] sp;
  logic                stack_full;
  logic                stack_empty;
  logic                overflow;
  logic                underflow;

  modport master (
    output hold, jmp, jmp_nz, dont_jmp, call, ret, jmp_addr,
    input  pm_addr, pc, sp, stack_full, stack_empty, overflow, underflow
  );

  modport slave (
    input  hold, jmp, jmp_nz, dont_jmp, call, ret, jmp_addr,
    output pm_addr, pc, sp, stack_full, stack_empty, overflow, underflow
  );
endinterface

// File: rtl/program_sequencer_stack.sv
// Program counter sequencer with jump/call/return and a small LIFO return-address stack.
// pm_addr is the combinational next-fetch address; pc registers it every clock.
module program_sequencer_stack #(
  parameter int PC_WIDTH    = 8,
  parameter int JA_WIDTH    = 4,
  parameter int STACK_DEPTH = 4,
  parameter int SP_WIDTH    = $clog2(STACK_DEPTH + 1)
) (
  input logic                      clk,
  input logic                      reset_n,
  program_sequencer_stack_if.slave bus
);

  logic [PC_WIDTH-1:0] pc_reg;
  logic [SP_WIDTH-1:0] sp_reg;
  logic [SP_WIDTH-1:0] sp_next;
  logic                overflow_reg;
  logic                underflow_reg;
  logic [PC_WIDTH-1:0] stack_reg [STACK_DEPTH];

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] top_entry;
  logic [PC_WIDTH-1:0] pm_addr_next;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                overflow_set;
  logic                underflow_set;

  assign full   = (sp_reg == SP_WIDTH'(STACK_DEPTH));
  assign empty  = (sp_reg == '0);
  assign pc_inc = pc_reg + PC_WIDTH'(1);
  // Shift rather than concatenate so JA_WIDTH == PC_WIDTH needs no zero-width field.
  assign target = PC_WIDTH'(bus.jmp_addr) << (PC_WIDTH - JA_WIDTH);

  always_comb begin
    top_entry = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_reg == SP_WIDTH'(i + 1)) top_entry = stack_reg[i];
    end
  end

  always_comb begin
    pm_addr_next  = pc_inc;
    push          = 1'b0;
    pop           = 1'b0;
    overflow_set  = 1'b0;
    underflow_set = 1'b0;
    if (!reset_n) begin
      pm_addr_next = '0;
    end else if (bus.hold) begin
      pm_addr_next = pc_reg;
    end else if (bus.ret) begin
      if (empty) begin
        underflow_set = 1'b1;
      end else begin
        pm_addr_next = top_entry;
        pop          = 1'b1;
      end
    end else if (bus.call) begin
      // A call on a full stack still jumps; only the return address is lost.
      pm_addr_next = target;
      if (full) overflow_set = 1'b1;
      else      push         = 1'b1;
    end else if (bus.jmp || (bus.jmp_nz && !bus.dont_jmp)) begin
      pm_addr_next = target;
    end
  end

  always_comb begin
    sp_next = sp_reg;
    if (push)     sp_next = sp_reg + SP_WIDTH'(1);
    else if (pop) sp_next = sp_reg - SP_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_reg        <= '0;
      sp_reg        <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      pc_reg        <= pm_addr_next;
      sp_reg        <= sp_next;
      overflow_reg  <= overflow_reg | overflow_set;
      underflow_reg <= underflow_reg | underflow_set;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) stack_reg[i] <= '0;
    end else begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (push && sp_reg == SP_WIDTH'(i)) stack_reg[i] <= pc_inc;
      end
    end
  end

  assign bus.pm_addr     = pm_addr_next;
  assign bus.pc          = pc_reg;
  assign bus.sp          = sp_reg;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.overflow    = overflow_reg;
  assign bus.underflow   = underflow_reg;

endmodule

// File: tb/tb_program_sequencer_stack.sv
// Directed bench for program_sequencer_stack: a vector table walked from reset plus
// hand-written sequences for wrap, nested calls, hold and asynchronous reset.
module tb_program_sequencer_stack;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  program_sequencer_stack_if #(.PC_WIDTH(8), .JA_WIDTH(4), .STACK_DEPTH(4)) bus_if ();

  program_sequencer_stack #(.PC_WIDTH(8), .JA_WIDTH(4), .STACK_DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       hold;
    logic       jmp;
    logic       jmp_nz;
    logic       dont_jmp;
    logic       call;
    logic       ret;
    logic [3:0] ja;
    logic [7:0] exp_pm;
    logic [7:0] exp_pc;
    logic [2:0] exp_sp;
    logic       exp_ovf;
    logic       exp_unf;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(input logic h, input logic j, input logic jnz, input logic dj,
                              input logic c, input logic r, input logic [3:0] ja,
                              input logic [7:0] pm, input logic [7:0] pcv, input logic [2:0] spv,
                              input logic o, input logic u);
    vec_t v;
    v.hold = h; v.jmp = j; v.jmp_nz = jnz; v.dont_jmp = dj; v.call = c; v.ret = r; v.ja = ja;
    v.exp_pm = pm; v.exp_pc = pcv; v.exp_sp = spv; v.exp_ovf = o; v.exp_unf = u;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic h, input logic j, input logic jnz, input logic dj,
                       input logic c, input logic r, input logic [3:0] ja);
    bus_if.hold     = h;
    bus_if.jmp      = j;
    bus_if.jmp_nz   = jnz;
    bus_if.dont_jmp = dj;
    bus_if.call     = c;
    bus_if.ret      = r;
    bus_if.jmp_addr = ja;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across a few edges with requests asserted, then release between edges.
  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h7);
    tick();
    tick();
    chk("reset_pm_addr", 32'(bus_if.pm_addr), 32'h0);
    chk("reset_pc", 32'(bus_if.pc), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    //            h    j    jnz  dj   c    r    ja    pm     pc     sp  o  u
    vecs[0]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 8'h01, 8'h01, 0, 0, 0);
    vecs[1]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'h1, 8'h10, 8'h10, 0, 0, 0);
    vecs[2]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 8'h11, 8'h11, 0, 0, 0);
    vecs[3]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 8'h12, 8'h12, 0, 0, 0);
    vecs[4]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,4'h3, 8'h30, 8'h30, 1, 0, 0);
    vecs[5]  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,4'h3, 8'h30, 8'h30, 1, 0, 0);
    vecs[6]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 8'h31, 8'h31, 1, 0, 0);
    vecs[7]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 8'h32, 8'h32, 1, 0, 0);
    vecs[8]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 8'h33, 8'h33, 1, 0, 0);
    vecs[9]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 8'h34, 8'h34, 1, 0, 0);
    vecs[10] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'h0, 8'h35, 8'h35, 1, 0, 0);
    vecs[11] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,4'h0, 8'h13, 8'h13, 0, 0, 0);
    vecs[12] = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,4'h0, 8'h14, 8'h14, 0, 0, 1);
    vecs[13] = mk(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,4'h9, 8'h15, 8'h15, 0, 0, 1);
    vecs[14] = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,4'h9, 8'h90, 8'h90, 0, 0, 1);
    vecs[15] = mk(1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,4'h4, 8'h90, 8'h90, 0, 0, 1);
    vecs[16] = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,4'h4, 8'h90, 8'h90, 0, 0, 1);
    vecs[17] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,4'h4, 8'h91, 8'h91, 0, 0, 1);
    vecs[18] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,4'h4, 8'h40, 8'h40, 1, 0, 1);
    vecs[19] = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,4'h5, 8'h92, 8'h92, 0, 0, 1);
    vecs[20] = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'hF, 8'hF0, 8'hF0, 0, 0, 1);
    vecs[21] = mk(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,4'h2, 8'h20, 8'h20, 0, 0, 1);

    // Reset state
    do_reset();
    chk("post_reset_pc", 32'(bus_if.pc), 32'h0);
    chk("post_reset_sp", 32'(bus_if.sp), 32'h0);
    chk("post_reset_empty", 32'(bus_if.stack_empty), 32'h1);
    chk("post_reset_full", 32'(bus_if.stack_full), 32'h0);
    chk("post_reset_ovf", 32'(bus_if.overflow), 32'h0);
    chk("post_reset_unf", 32'(bus_if.underflow), 32'h0);

    // Vector table
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].hold, vecs[i].jmp, vecs[i].jmp_nz, vecs[i].dont_jmp,
            vecs[i].call, vecs[i].ret, vecs[i].ja);
      #1;
      chk($sformatf("vec%0d_pm_addr", i), 32'(bus_if.pm_addr), 32'(vecs[i].exp_pm));
      tick();
      chk($sformatf("vec%0d_pc", i), 32'(bus_if.pc), 32'(vecs[i].exp_pc));
      chk($sformatf("vec%0d_sp", i), 32'(bus_if.sp), 32'(vecs[i].exp_sp));
      chk($sformatf("vec%0d_ovf", i), 32'(bus_if.overflow), 32'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d_unf", i), 32'(bus_if.underflow), 32'(vecs[i].exp_unf));
      $display("vec %0d: pc=%h sp=%0d ovf=%0b unf=%0b", i, bus_if.pc, bus_if.sp,
               bus_if.overflow, bus_if.underflow);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    // Free-running count with wrap
    do_reset();
    for (int k = 0; k < 300; k++) begin
      tick();
      chk($sformatf("idle%0d_pc", k), 32'(bus_if.pc), 32'((k + 1) % 256));
    end
    chk("idle_ovf", 32'(bus_if.overflow), 32'h0);
    chk("idle_unf", 32'(bus_if.underflow), 32'h0);
    chk("idle_sp", 32'(bus_if.sp), 32'h0);
    $display("idle: 300 cycles, pc=%h", bus_if.pc);

    // Nested calls past the stack depth, then LIFO returns
    do_reset();
    for (int k = 0; k < 7; k++) tick();
    chk("nest_start_pc", 32'(bus_if.pc), 32'h07);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'(i));
      #1;
      chk($sformatf("call%0d_pm_addr", i), 32'(bus_if.pm_addr), 32'(i * 16));
      tick();
      chk($sformatf("call%0d_pc", i), 32'(bus_if.pc), 32'(i * 16));
      chk($sformatf("call%0d_sp", i), 32'(bus_if.sp), 32'((i > 4) ? 4 : i));
      chk($sformatf("call%0d_ovf", i), 32'(bus_if.overflow), 32'(i == 5));
      $display("call %0d: pc=%h sp=%0d ovf=%0b", i, bus_if.pc, bus_if.sp, bus_if.overflow);
    end
    chk("nest_full", 32'(bus_if.stack_full), 32'h1);
    begin
      logic [7:0] ret_exp [4];
      ret_exp[0] = 8'h31; ret_exp[1] = 8'h21; ret_exp[2] = 8'h11; ret_exp[3] = 8'h08;
      for (int k = 0; k < 4; k++) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
        #1;
        chk($sformatf("ret%0d_pm_addr", k), 32'(bus_if.pm_addr), 32'(ret_exp[k]));
        tick();
        chk($sformatf("ret%0d_pc", k), 32'(bus_if.pc), 32'(ret_exp[k]));
        chk($sformatf("ret%0d_sp", k), 32'(bus_if.sp), 32'(3 - k));
        $display("ret %0d: pc=%h sp=%0d", k, bus_if.pc, bus_if.sp);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("nest_empty", 32'(bus_if.stack_empty), 32'h1);
    chk("nest_ovf_sticky", 32'(bus_if.overflow), 32'h1);
    chk("nest_unf", 32'(bus_if.underflow), 32'h0);

    // Asynchronous reset with two entries pushed and overflow set
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h6);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h7);
    tick();
    chk("pre_areset_sp", 32'(bus_if.sp), 32'h2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_pc", 32'(bus_if.pc), 32'h0);
    chk("areset_sp", 32'(bus_if.sp), 32'h0);
    chk("areset_ovf", 32'(bus_if.overflow), 32'h0);
    chk("areset_pm_addr", 32'(bus_if.pm_addr), 32'h0);
    $display("async reset: pc=%h sp=%0d ovf=%0b", bus_if.pc, bus_if.sp, bus_if.overflow);

    // Hold stalls a pending call, which runs once hold drops
    do_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h4);
    tick();
    chk("hold_start_pc", 32'(bus_if.pc), 32'h40);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h6);
      #1;
      chk($sformatf("hold%0d_pm_addr", k), 32'(bus_if.pm_addr), 32'h40);
      tick();
      chk($sformatf("hold%0d_pc", k), 32'(bus_if.pc), 32'h40);
      chk($sformatf("hold%0d_sp", k), 32'(bus_if.sp), 32'h0);
      $display("hold %0d: pc=%h sp=%0d", k, bus_if.pc, bus_if.sp);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h6);
    #1;
    chk("unhold_pm_addr", 32'(bus_if.pm_addr), 32'h60);
    tick();
    chk("unhold_pc", 32'(bus_if.pc), 32'h60);
    chk("unhold_sp", 32'(bus_if.sp), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    #1;
    chk("unhold_ret_pm_addr", 32'(bus_if.pm_addr), 32'h41);
    tick();
    chk("unhold_ret_pc", 32'(bus_if.pc), 32'h41);
    chk("unhold_ret_sp", 32'(bus_if.sp), 32'h0);
    $display("unhold: call then ret, pc=%h sp=%0d", bus_if.pc, bus_if.sp);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
